feedback_packet_rx: RTL

- Upstream stage of the Q-table update block.
- Accepts received radio packets as a stream of 16-bit words, filters them, and extracts fSourceID, fClusterID, fEnergyLeft, fQValue and packetType.
- Presents those fields with a one-cycle en pulse to the Q-table updater, then holds them stable until the updater returns done.
- Back-pressures the link while an update is outstanding.

---
 rtl/feedback_packet_rx.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/feedback_packet_rx.sv
// Receive-side packet filter feeding the Q-table updater: collects a header+field packet,
// filters on type mask / own source ID, then hands fields over with an en/done handshake.
// Optional word5 XOR checksum check: define FEEDBACK_RX_CHECKSUM_EN.
//
// state       | meaning
// S_IDLE      | waiting for a header word (in_sop)
// S_COLLECT   | storing payload words into shadow fields
// S_CHECK     | filter decision; copy shadows to outputs on accept
// S_ISSUE     | raise en, count packet, arm done timer
// S_WAIT_DONE | link stalled until upd_done or timer expiry
module feedback_packet_rx #(
  parameter int          WORD_WIDTH   = 16,
  parameter logic [7:0]  ACCEPT_MASK  = 8'b0000_0110,
  parameter int          DONE_TIMEOUT = 64
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic [WORD_WIDTH-1:0] node_id,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  output logic                  in_ready,
  output logic [WORD_WIDTH-1:0] fSourceID,
  output logic [WORD_WIDTH-1:0] fClusterID,
  output logic [WORD_WIDTH-1:0] fEnergyLeft,
  output logic [WORD_WIDTH-1:0] fQValue,
  output logic [2:0]            packetType,
  output logic                  en,
  input  logic                  upd_done,
  output logic                  busy,
  output logic [15:0]           pkt_count,
  output logic [15:0]           drop_count,
  output logic                  timeout_err
`ifdef FEEDBACK_RX_CHECKSUM_EN
  ,
  output logic                  chk_err
`endif
);

`ifdef FEEDBACK_RX_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif
  localparam int            TW      = $clog2(DONE_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_ISSUE,
    S_WAIT_DONE
  } state_t;

  state_t                r_state;
  logic [2:0]            r_idx;
  logic [2:0]            r_type;
  logic [WORD_WIDTH-1:0] r_sh_src, r_sh_clu, r_sh_eng, r_sh_q;
  logic [WORD_WIDTH-1:0] r_src, r_clu, r_eng, r_q;
  logic [2:0]            r_pkt_type;
  logic                  r_in_ready, r_en, r_busy, r_to_err;
  logic [15:0]           r_pkt_cnt, r_drop_cnt;
  logic [TW-1:0]         r_timer;

  logic                  w_xfer;
  logic                  w_chk_bad;
  logic                  w_drop;
  logic [2:0]            w_hdr_type;

`ifdef FEEDBACK_RX_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] r_sh_chk;
  logic [WORD_WIDTH-1:0] r_xor;
  logic                  r_chk_err;
  assign w_chk_bad = (r_xor != r_sh_chk);
  assign chk_err   = r_chk_err;
`else
  assign w_chk_bad = 1'b0;
`endif

  assign w_xfer     = in_valid && r_in_ready;
  assign w_hdr_type = in_data[WORD_WIDTH-1 -: 3];
  assign w_drop     = !ACCEPT_MASK[r_type] || (r_sh_src == node_id) || w_chk_bad;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_idx      <= 3'd0;
      r_type     <= 3'd0;
      r_sh_src   <= '0;
      r_sh_clu   <= '0;
      r_sh_eng   <= '0;
      r_sh_q     <= '0;
      r_src      <= '0;
      r_clu      <= '0;
      r_eng      <= '0;
      r_q        <= '0;
      r_pkt_type <= 3'd0;
      r_in_ready <= 1'b0;
      r_en       <= 1'b0;
      r_busy     <= 1'b0;
      r_to_err   <= 1'b0;
      r_pkt_cnt  <= 16'd0;
      r_drop_cnt <= 16'd0;
      r_timer    <= '0;
`ifdef FEEDBACK_RX_CHECKSUM_EN
      r_sh_chk   <= '0;
      r_xor      <= '0;
      r_chk_err  <= 1'b0;
`endif
    end else begin
      r_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_xfer && in_sop) begin
            r_type  <= w_hdr_type;
            r_idx   <= 3'd1;
            r_state <= S_COLLECT;
`ifdef FEEDBACK_RX_CHECKSUM_EN
            r_xor   <= in_data;
`endif
          end
        end
        S_COLLECT: begin
          if (w_xfer) begin
            if (in_sop) begin
              // restart on a fresh header; the abandoned partial counts as a drop
              r_drop_cnt <= sat_inc(r_drop_cnt);
              r_type     <= w_hdr_type;
              r_idx      <= 3'd1;
`ifdef FEEDBACK_RX_CHECKSUM_EN
              r_xor      <= in_data;
`endif
            end else begin
              case (r_idx)
                3'd1:    r_sh_src <= in_data;
                3'd2:    r_sh_clu <= in_data;
                3'd3:    r_sh_eng <= in_data;
                3'd4:    r_sh_q   <= in_data;
`ifdef FEEDBACK_RX_CHECKSUM_EN
                3'd5:    r_sh_chk <= in_data;
`endif
                default: ;
              endcase
`ifdef FEEDBACK_RX_CHECKSUM_EN
              if (r_idx != LAST_IDX) r_xor <= r_xor ^ in_data;
`endif
              r_idx <= r_idx + 3'd1;
              if (r_idx == LAST_IDX) begin
                r_state    <= S_CHECK;
                r_in_ready <= 1'b0;
              end
            end
          end
        end
        S_CHECK: begin
          if (w_drop) begin
            r_drop_cnt <= sat_inc(r_drop_cnt);
            r_in_ready <= 1'b1;
            r_state    <= S_IDLE;
`ifdef FEEDBACK_RX_CHECKSUM_EN
            if (w_chk_bad) r_chk_err <= 1'b1;
`endif
          end else begin
            r_src      <= r_sh_src;
            r_clu      <= r_sh_clu;
            r_eng      <= r_sh_eng;
            r_q        <= r_sh_q;
            r_pkt_type <= r_type;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_en      <= 1'b1;
          r_busy    <= 1'b1;
          r_pkt_cnt <= sat_inc(r_pkt_cnt);
          r_timer   <= TO_LOAD;
          r_state   <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // done takes priority over a coincident timer expiry
          if (upd_done) begin
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= S_IDLE;
          end else if (r_timer == '0) begin
            r_to_err   <= 1'b1;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: begin
          r_in_ready <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign fSourceID   = r_src;
  assign fClusterID  = r_clu;
  assign fEnergyLeft = r_eng;
  assign fQValue     = r_q;
  assign packetType  = r_pkt_type;
  assign en          = r_en;
  assign busy        = r_busy;
  assign pkt_count   = r_pkt_cnt;
  assign drop_count  = r_drop_cnt;
  assign timeout_err = r_to_err;

endmodule
